conv_encoder_k7: RTL

- Rate-1/2 feedforward convolutional encoder. It produces the code-symbol pairs that the branch-metric and Viterbi decoder path consumes.
- Bit-serial, frame-based input; one output pair per encoded bit.
- Valid/ready handshake on both sides.
- Optional zero-tail flush returns the trellis to state 0 at end of frame.

---
 rtl/conv_encoder_k7.sv | 98 +++++++++
 1 files changed

// File: rtl/conv_encoder_k7.sv
// conv_encoder_k7: rate-1/2 feedforward convolutional encoder (K=7, G0=171o, G1=133o)
//   with bit-serial frame input, valid/ready on both sides and a one-register output stage.
//   Optional zero-tail flush enabled by defining CONV_ENC_TAIL_EN.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_bit, in_valid, in_last   information bit stream, in_last marks the final bit of a frame
//   in_ready                    encoder accepts input this cycle
//   out_pair[1:0]               {G1 parity, G0 parity}
//   out_valid, out_last         pair valid, final pair of frame
//   out_ready                   downstream accepts out_pair
//   busy                        frame in progress (DATA or TAIL)
module conv_encoder_k7 #(
    parameter int             K  = 7,
    parameter logic [K-1:0]   G0 = 7'o171,
    parameter logic [K-1:0]   G1 = 7'o133
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [1:0] out_pair,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    state_t       state_q, state_d;
    logic [K-2:0] s_q, s_d;
    logic [1:0]   out_pair_q, out_pair_d;
    logic         out_valid_q, out_valid_d;
    logic         out_last_q, out_last_d;
    logic         load, accept, tail_step, step, b, last;
    logic [K-1:0] t;
    logic [1:0]   par;
`ifdef CONV_ENC_TAIL_EN
    localparam int CW = $clog2(K);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        load      = !out_valid_q || out_ready;
        in_ready  = (state_q != TAIL) && load;
        accept    = in_valid && in_ready;
        tail_step = (state_q == TAIL) && load;
        step      = accept || tail_step;
        // tail cycles shift in zeros
        b         = (state_q != TAIL) && in_bit;
        t         = {b, s_q};
        par       = {^(t & G1), ^(t & G0)};
`ifdef CONV_ENC_TAIL_EN
        last      = tail_step && (cnt_q == '0);
        s_d       = step ? {b, s_q[K-2:1]} : s_q;
        state_d   = (state_q == TAIL) ? (last ? IDLE : TAIL) :
                    accept ? (in_last ? TAIL : DATA) : state_q;
        cnt_d     = (accept && in_last) ? CW'(K-2) :
                    (tail_step && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
`else
        last      = accept && in_last;
        // clearing s at the final bit lets the next frame start from state 0
        s_d       = !step ? s_q : in_last ? '0 : {b, s_q[K-2:1]};
        state_d   = accept ? (in_last ? IDLE : DATA) : state_q;
`endif
        out_valid_d = load ? step : out_valid_q;
        out_pair_d  = step ? par : out_pair_q;
        out_last_d  = load ? last : out_last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= '0;
            out_pair_q  <= 2'b00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            out_pair_q  <= out_pair_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
`ifdef CONV_ENC_TAIL_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign out_pair  = out_pair_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
endmodule
